// File: rtl/adc_scan_sequencer_if.sv
// Bus bundle for adc_scan_sequencer: scan control, SAR converter handshake,
// result stream and per-channel result read port.
interface adc_scan_sequencer_if #(
    parameter int unsigned NCH = 4
);
    localparam int unsigned SelW = $clog2(NCH);

    logic            enable;
    logic            mode_cont;
    logic [NCH-1:0]  ch_mask;
    logic            adc_eoc;
    logic [7:0]      adc_value;
    logic            adc_start;
    logic [SelW-1:0] mux_sel;
    logic            result_valid;
    logic [SelW-1:0] result_ch;
    logic [7:0]      result_data;
    logic [SelW-1:0] rd_ch;
    logic [7:0]      rd_data;
    logic            scan_done;
    logic            busy;
    logic            timeout_err;

    modport master (
        input  enable, mode_cont, ch_mask, adc_eoc, adc_value, rd_ch,
        output adc_start, mux_sel, result_valid, result_ch, result_data, rd_data,
               scan_done, busy, timeout_err
    );

    modport slave (
        output enable, mode_cont, ch_mask, adc_eoc, adc_value, rd_ch,
        input  adc_start, mux_sel, result_valid, result_ch, result_data, rd_data,
               scan_done, busy, timeout_err
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Multi-channel SAR scan sequencer: walks the enabled channels lowest-first,
// settles the mux, runs one conversion per channel and stores each result.
module adc_scan_sequencer #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned RELEASE_CYC = 2
) (
    input logic                  clock,
    input logic                  reset,
    adc_scan_sequencer_if.master bus
);
    localparam int unsigned SelW = $clog2(NCH);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StConvert,
        StCapture,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [NCH-1:0]  scan_mask_q, scan_mask_d;  // channels still to convert this pass
    logic [SelW-1:0] mux_sel_q, mux_sel_d;
    logic [SelW-1:0] result_ch_q, result_ch_d;
    logic [7:0]      cap_val_q, cap_val_d;
    logic [7:0]      result_data_q, result_data_d;
    logic            abort_q, abort_d;
    logic            timeout_err_q, timeout_err_d;
    logic            result_valid_q, result_valid_d;
    logic            scan_done_q, scan_done_d;
    logic            wr_en;
    logic [7:0]      res_q [NCH];

    function automatic logic [SelW-1:0] lowest_ch(input logic [NCH-1:0] m);
        lowest_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = SelW'(i);
        end
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        scan_mask_d    = scan_mask_q;
        mux_sel_d      = mux_sel_q;
        result_ch_d    = result_ch_q;
        cap_val_d      = cap_val_q;
        result_data_d  = result_data_q;
        abort_d        = abort_q;
        timeout_err_d  = timeout_err_q;
        result_valid_d = 1'b0;
        scan_done_d    = 1'b0;
        wr_en          = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (bus.enable && (bus.ch_mask != '0)) begin
                    state_d       = StSelect;
                    scan_mask_d   = bus.ch_mask;
                    mux_sel_d     = lowest_ch(bus.ch_mask);
                    timeout_err_d = 1'b0;
                end
            end
            StSelect: begin
                cnt_d = '0;
                if (!bus.enable) begin
                    state_d = StRelease;
                    abort_d = 1'b1;
                end else begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!bus.enable) begin
                    state_d = StRelease;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_CYC - 1) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StConvert: begin
                // Abort wins over a coincident end-of-conversion: nothing is stored.
                if (!bus.enable) begin
                    state_d = StRelease;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (bus.adc_eoc) begin
                    state_d   = StCapture;
                    cap_val_d = bus.adc_value;
                    cnt_d     = '0;
                end else if (cnt_q == TIMEOUT_CYC - 1) begin
                    state_d                = StRelease;
                    timeout_err_d          = 1'b1;
                    scan_mask_d[mux_sel_q] = 1'b0;
                    cnt_d                  = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StCapture: begin
                wr_en                  = 1'b1;
                result_valid_d         = 1'b1;
                result_ch_d            = mux_sel_q;
                result_data_d          = cap_val_q;
                scan_mask_d[mux_sel_q] = 1'b0;
                abort_d                = !bus.enable;
                state_d                = StRelease;
                cnt_d                  = '0;
            end
            StRelease: begin
                if (cnt_q == RELEASE_CYC - 1) begin
                    cnt_d = '0;
                    if (abort_q) begin
                        state_d = StIdle;
                    end else if (scan_mask_q != '0) begin
                        state_d   = StSelect;
                        mux_sel_d = lowest_ch(scan_mask_q);
                    end else begin
                        scan_done_d = 1'b1;
                        if (bus.mode_cont && bus.enable && (bus.ch_mask != '0)) begin
                            state_d     = StSelect;
                            scan_mask_d = bus.ch_mask;
                            mux_sel_d   = lowest_ch(bus.ch_mask);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            scan_mask_q    <= '0;
            mux_sel_q      <= '0;
            result_ch_q    <= '0;
            cap_val_q      <= '0;
            result_data_q  <= '0;
            abort_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
            result_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) res_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            scan_mask_q    <= scan_mask_d;
            mux_sel_q      <= mux_sel_d;
            result_ch_q    <= result_ch_d;
            cap_val_q      <= cap_val_d;
            result_data_q  <= result_data_d;
            abort_q        <= abort_d;
            timeout_err_q  <= timeout_err_d;
            result_valid_q <= result_valid_d;
            scan_done_q    <= scan_done_d;
            if (wr_en) res_q[mux_sel_q] <= cap_val_q;
        end
    end

    assign bus.adc_start    = (state_q == StConvert);
    assign bus.mux_sel      = mux_sel_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_ch    = result_ch_q;
    assign bus.result_data  = result_data_q;
    assign bus.rd_data      = res_q[bus.rd_ch];
    assign bus.scan_done    = scan_done_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a SAR converter model and a
// result scoreboard checked on every result_valid pulse.
module tb_adc_scan_sequencer;
    localparam int unsigned NCH    = 4;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 1024;
    localparam int unsigned REL    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    adc_scan_sequencer_if #(.NCH(NCH)) bus ();

    adc_scan_sequencer #(
        .NCH(NCH),
        .SETTLE_CYC(SETTLE),
        .TIMEOUT_CYC(TMO),
        .RELEASE_CYC(REL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t           sb[$];
    int             n_total   = 0;
    int             n_bad     = 0;
    int             n_results = 0;
    int             n_done    = 0;
    int             cyc       = 0;
    int             eoc_cyc   = 0;
    logic [7:0]     conv_val [NCH];
    logic [NCH-1:0] no_resp = '0;

    task automatic chk(input string tag, input int got, input int want);
        n_total++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // SAR model: eoc three cycles after adc_start rises, cleared when start drops.
    initial begin
        int n;
        n = 0;
        bus.adc_eoc   = 1'b0;
        bus.adc_value = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            if (bus.adc_start !== 1'b1) begin
                bus.adc_eoc = 1'b0;
                n = 0;
            end else if (!bus.adc_eoc && !no_resp[bus.mux_sel]) begin
                n++;
                if (n == 3) begin
                    bus.adc_eoc   = 1'b1;
                    bus.adc_value = conv_val[bus.mux_sel];
                end
            end
        end
    end

    // Output monitor: scoreboard pop, result latency, scan_done count.
    initial begin
        logic last;
        last = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (bus.adc_start === 1'b1 && bus.adc_eoc === 1'b1 && !last) eoc_cyc = cyc;
            last = (bus.adc_start === 1'b1 && bus.adc_eoc === 1'b1);
            if (bus.scan_done === 1'b1) n_done++;
            if (bus.result_valid === 1'b1) begin
                n_results++;
                chk("rv_latency", cyc - eoc_cyc, 2);
                chk("rv_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rv_ch", int'(bus.result_ch), int'(e.ch));
                    chk("rv_data", int'(bus.result_data), int'(e.data));
                end
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_adc_start", int'(bus.adc_start), 0);
        chk("rst_mux_sel", int'(bus.mux_sel), 0);
        chk("rst_result_valid", int'(bus.result_valid), 0);
        chk("rst_result_ch", int'(bus.result_ch), 0);
        chk("rst_result_data", int'(bus.result_data), 0);
        chk("rst_scan_done", int'(bus.scan_done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_timeout_err", int'(bus.timeout_err), 0);
        for (int i = 0; i < int'(NCH); i++) begin
            bus.rd_ch = 2'(i);
            #1;
            chk("rst_rd_data", int'(bus.rd_data), 0);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.adc_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_busy_low(input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_rv_ch(input string tag, input int ch);
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.result_valid === 1'b1 && int'(bus.result_ch) == ch) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int n, hi, nrv, low, min_low, seen, mux_ok;
        for (int i = 0; i < int'(NCH); i++) conv_val[i] = 8'h00;
        bus.enable    = 1'b0;
        bus.mode_cont = 1'b0;
        bus.ch_mask   = '0;
        bus.rd_ch     = '0;

        repeat (3) @(negedge clock);
        check_reset_state();
        reset = 1'b0;

        // Single scan over channels 1 and 3.
        conv_val[1] = 8'h5A;
        conv_val[3] = 8'hC3;
        sb.push_back(exp_t'{2'd1, 8'h5A});
        sb.push_back(exp_t'{2'd3, 8'hC3});
        n_results = 0;
        n_done    = 0;
        @(negedge clock);
        bus.ch_mask   = 4'b1010;
        bus.mode_cont = 1'b0;
        bus.enable    = 1'b1;
        mux_ok = 1;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.mux_sel !== 2'd1) mux_ok = 0;
            if (bus.adc_start === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("start_latency", n, 1 + int'(SETTLE) + 1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.mux_sel !== 2'd1) mux_ok = 0;
            if (bus.result_valid === 1'b1) begin
                n = 1;
                break;
            end
        end
        @(negedge clock);
        if (bus.mux_sel !== 2'd1) mux_ok = 0;
        chk("rv_ch1_seen", n, 1);
        chk("mux_stable", mux_ok, 1);
        @(negedge clock);
        chk("mux_next_ch", int'(bus.mux_sel), 3);
        wait_rv_ch("rv_ch3_seen", 3);
        bus.enable = 1'b0;
        wait_busy_low("scan_a_idle");
        chk("scan_a_done_cnt", n_done, 1);
        chk("scan_a_results", n_results, 2);
        bus.rd_ch = 2'd3;
        #1;
        chk("rd_ch3", int'(bus.rd_data), 'hC3);
        bus.rd_ch = 2'd1;
        #1;
        chk("rd_ch1", int'(bus.rd_data), 'h5A);
        chk("scan_a_no_tmo", int'(bus.timeout_err), 0);

        // Channel 0 never answers; channel 1 must still be converted.
        no_resp     = 4'b0001;
        conv_val[1] = 8'h77;
        sb.push_back(exp_t'{2'd1, 8'h77});
        n_results = 0;
        n_done    = 0;
        @(negedge clock);
        bus.ch_mask = 4'b0011;
        bus.enable  = 1'b1;
        wait_start(n);
        chk("tmo_start", n, 1 + int'(SETTLE) + 1);
        hi = 1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            if (bus.adc_start === 1'b1) hi++;
            else break;
        end
        chk("tmo_convert_len", hi, int'(TMO));
        chk("tmo_err_set", int'(bus.timeout_err), 1);
        chk("tmo_no_result", n_results, 0);
        wait_rv_ch("tmo_next_ch", 1);
        bus.enable = 1'b0;
        wait_busy_low("tmo_idle");
        chk("tmo_done_cnt", n_done, 1);
        chk("tmo_results", n_results, 1);
        chk("tmo_err_sticky", int'(bus.timeout_err), 1);
        bus.rd_ch = 2'd1;
        #1;
        chk("rd_ch1_after_tmo", int'(bus.rd_data), 'h77);
        bus.rd_ch = 2'd0;
        #1;
        chk("rd_ch0_not_stored", int'(bus.rd_data), 0);

        // Continuous scan of channel 0 for three passes.
        no_resp     = 4'b0000;
        conv_val[0] = 8'h11;
        for (int i = 0; i < 3; i++) sb.push_back(exp_t'{2'd0, 8'h11});
        n_results = 0;
        n_done    = 0;
        @(negedge clock);
        bus.ch_mask   = 4'b0001;
        bus.mode_cont = 1'b1;
        bus.enable    = 1'b1;
        @(negedge clock);
        chk("tmo_clear_on_exit", int'(bus.timeout_err), 0);
        nrv     = 0;
        low     = 0;
        seen    = 0;
        min_low = 1000;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.adc_start === 1'b1) begin
                if (seen != 0 && low > 0 && low < min_low) min_low = low;
                seen = 1;
                low  = 0;
            end else begin
                low++;
            end
            if (bus.result_valid === 1'b1) nrv++;
            if (nrv == 3) begin
                bus.enable = 1'b0;
                break;
            end
        end
        chk("cont_results", nrv, 3);
        wait_busy_low("cont_idle");
        chk("cont_done_cnt", n_done, 3);
        chk("cont_start_gap", int'(min_low >= int'(REL) && min_low < 1000), 1);
        bus.mode_cont = 1'b0;

        // Abort in SETTLE, then reset in CONVERT of a new scan.
        n_results = 0;
        n_done    = 0;
        @(negedge clock);
        bus.ch_mask = 4'b0100;
        bus.enable  = 1'b1;
        hi = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.adc_start === 1'b1) hi = 1;
        end
        bus.enable = 1'b0;
        chk("abort_no_start", hi, 0);
        wait_busy_low("abort_idle");
        chk("abort_no_result", n_results, 0);
        chk("abort_no_done", n_done, 0);
        bus.enable = 1'b1;
        wait_start(n);
        chk("rst_scan_start", n, 1 + int'(SETTLE) + 1);
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_state();
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("post_rst_no_result", n_results, 0);
        chk("post_rst_no_done", n_done, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of analog channels (2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 16, mux settling cycles before each conversion (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, max CONVERT cycles waiting for adc_eoc.
REQ-004 SHALL have parameter RELEASE_CYC, default 2, cycles adc_start is held low between conversions (>=1).
REQ-005 SHALL have port: clock  in  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: enable  in  1  level; high requests scanning.
REQ-008 SHALL have port: mode_cont  in  1  1 = continuous scan, 0 = single scan.
REQ-009 SHALL have port: ch_mask  in  NCH  per-channel enable bitmap.
REQ-010 SHALL have port: adc_eoc  in  1  end-of-conversion from SAR converter.
REQ-011 SHALL have port: adc_value  in  8  SAR result, valid while adc_eoc high.
REQ-012 SHALL have port: adc_start  out  1  SAR run level; low clears/arms converter.
REQ-013 SHALL have port: mux_sel  out  clog2(NCH)  analog mux channel select.
REQ-014 SHALL have port: result_valid  out  1  one-cycle pulse per stored result.
REQ-015 SHALL have port: result_ch  out  clog2(NCH)  channel of current result.
REQ-016 SHALL have port: result_data  out  8  value of current result.
REQ-017 SHALL have port: rd_ch  in  clog2(NCH), rd_data  out  8  combinational read of per-channel result register.
REQ-018 SHALL have port: scan_done  out  1  one-cycle pulse at end of each scan pass.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port: timeout_err  out  1  sticky; set on conversion timeout.

Function
REQ-021 SHALL implement FSM states IDLE, SELECT, SETTLE, CONVERT, CAPTURE, RELEASE.
REQ-022 IDLE: when enable=1 and ch_mask!=0, SHALL latch ch_mask into scan_mask and go to SELECT; ch_mask==0 keeps IDLE, no pulses.
REQ-023 SELECT (1 cycle): SHALL drive mux_sel to lowest set scan_mask bit not yet converted this pass, then SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles with adc_start=0, then CONVERT.
REQ-025 CONVERT SHALL hold adc_start=1; adc_eoc sampled high -> CAPTURE; adc_eoc while adc_start=0 SHALL be ignored.
REQ-026 CAPTURE (1 cycle): SHALL write adc_value into result register [mux_sel], update result_ch/result_data, pulse result_valid next cycle-edge (registered, 1 cycle wide), go to RELEASE.
REQ-027 RELEASE SHALL hold adc_start=0 for RELEASE_CYC cycles, then: more channels -> SELECT; last channel -> pulse scan_done, then SELECT of lowest channel if mode_cont=1 and enable=1 (re-latching ch_mask; if now 0 -> IDLE), else IDLE.
REQ-028 Latency: adc_start rises exactly 1+SETTLE_CYC cycles after IDLE exit; result_valid asserts 2 cycles after the cycle adc_eoc is first sampled high.
REQ-029 Timeout: CONVERT lasting TIMEOUT_CYC cycles without adc_eoc SHALL set timeout_err, skip storage (no result_valid), go to RELEASE; scan continues.
REQ-030 enable low in SELECT/SETTLE/CONVERT SHALL abort: next state RELEASE with adc_start=0, no storage, then IDLE, no scan_done.
REQ-031 enable low during CAPTURE SHALL still store that result, then RELEASE -> IDLE without scan_done.
REQ-032 ch_mask changes during a pass SHALL not affect that pass.
REQ-033 timeout_err SHALL clear only on reset or on IDLE exit.

Reset
REQ-034 On reset=1 at a clock edge SHALL enter IDLE; adc_start=0, mux_sel=0, result_valid=0, result_ch=0, result_data=0, scan_done=0, busy=0, timeout_err=0, all result registers=0x00.
REQ-035 Reset mid-conversion SHALL drop adc_start the following cycle and discard any pending adc_eoc.

Verification
REQ-036 NCH=4, mask=4'b1010, single, converter model returns 0x5A ch1, 0xC3 ch3 -> result_valid twice (ch1 0x5A, ch3 0xC3), one scan_done, IDLE; rd_ch=3 gives 0xC3.
REQ-037 SETTLE_CYC=16, enable rises in IDLE -> adc_start high exactly 17 cycles later; mux_sel stable from SELECT until RELEASE ends.
REQ-038 adc_eoc never asserted, TIMEOUT_CYC=1024 -> adc_start falls after 1024 CONVERT cycles, timeout_err=1, no result_valid, next channel proceeds.
REQ-039 mode_cont=1, mask=4'b0001, three passes -> three scan_done pulses, adc_start low >=RELEASE_CYC cycles between each conversion.
REQ-040 enable dropped in SETTLE, then reset asserted in CONVERT of a new scan -> abort without storage/scan_done; after reset all outputs and registers at REQ-034 values.
